// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: widths, op and state
// encodings, and small sign helpers used by the sequencer.
package div_sequencer_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ITER  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } div_state_e;

  // Two's-complement negate when en is set; -0x80000000 stays 0x80000000,
  // which is exactly the magnitude the unsigned core needs.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EXE-stage handshake between the pipeline and the divide sequencer.
interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            div_running;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  div_running, result_valid, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output div_running, result_valid, result
  );
endinterface

// File: rtl/div_sequencer_core.sv
// Restoring divide datapath: quotient/remainder registers and one
// compare-subtract-shift step per cycle. Pure datapath, no control.
module div_core
  import div_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] load_dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            fits;

  // rem_r < divisor keeps rem_shift below 2*divisor, so bit XLEN of the
  // 33-bit difference is a clean borrow flag.
  always_comb begin
    rem_shift = {rem_r, q_r[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    fits      = ~rem_diff[XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= '0;
      rem_r <= '0;
    end else if (load) begin
      q_r   <= load_dividend;
      rem_r <= '0;
    end else if (step) begin
      rem_r <= fits ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      q_r   <= {q_r[XLEN-2:0], fits};
    end
  end

  assign quotient  = q_r;
  assign remainder = rem_r;

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: FSM, iteration counter, special-case
// detection, sign fixup and the div_running stall status for EXE.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  div_sequencer_if.slave    bus
);

  div_state_e        state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              sel_rem_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic [XLEN-1:0]   divisor_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              is_signed;
  logic              div_zero;
  logic              overflow;
  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN-1:0]   fixed_res;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic              running;
  logic              valid;

  // Operand decode on the raw EXE inputs.
  always_comb begin
    is_signed   = ~bus.op[0];
    div_zero    = (bus.divisor == '0);
    overflow    = is_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                            && (bus.divisor == '1);
    special     = div_zero | overflow;
    if (div_zero) special_res = bus.op[1] ? bus.dividend : '1;
    else          special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept      = (state == IDLE) && bus.start && !bus.flush;
    fixed_res   = sel_rem_q ? neg_if(remainder, neg_r_q) : neg_if(quotient, neg_q_q);
  end

  // NOTE: every register, including the datapath ones, is cleared by reset so
  // result reads 0 immediately and no X can leak into EXE forwarding.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    if (bus.flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) next_state = special ? DONE : ITER;
        ITER:    if (cnt == '0) next_state = FIXUP;
        FIXUP:   next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Reset gates the combinational terms so the stall drops at once even
  // while EXE still holds start.
  always_comb begin
    running = 1'b0;
    valid   = 1'b0;
    if (!nrst && !bus.flush) begin
      running = (state == ITER) || (state == FIXUP) || ((state == IDLE) && bus.start);
      valid   = (state == DONE);
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      cnt       <= '0;
      sel_rem_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      divisor_q <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        cnt       <= CNT_W'(XLEN - 1);
        sel_rem_q <= bus.op[1];
        neg_q_q   <= is_signed & (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
        neg_r_q   <= is_signed & bus.dividend[XLEN-1];
        divisor_q <= neg_if(bus.divisor, is_signed & bus.divisor[XLEN-1]);
      end else if (state == ITER) begin
        cnt <= cnt - 1'b1;
      end
      // Loaded only on a real entry into DONE, so a flushed op leaves it alone.
      if (next_state == DONE)
        result_q <= (state == IDLE) ? special_res : fixed_res;
    end
  end

  div_core u_core (
    .clk           (clk),
    .rst           (nrst),
    .load          (accept),
    .step          (state == ITER),
    .load_dividend (neg_if(bus.dividend, is_signed & bus.dividend[XLEN-1])),
    .divisor       (divisor_q),
    .quotient      (quotient),
    .remainder     (remainder)
  );

  assign bus.div_running  = running;
  assign bus.result_valid = valid;
  assign bus.result       = result_q;

endmodule
